// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the register/immediate arithmetic controller.
//   - Instruction type encodings (R / I; everything else is illegal)
//   - ADD/SUB mode encodings forwarded to the execution unit
//   - Controller state encodings and a legality helper
package exec_ctrl_pkg;

    localparam logic [1:0] OP_R = 2'd0;
    localparam logic [1:0] OP_I = 2'd1;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] ctrl_state_t;

    localparam ctrl_state_t ST_IDLE        = 3'd0;
    localparam ctrl_state_t ST_RF_READ     = 3'd1;
    localparam ctrl_state_t ST_ISSUE       = 3'd2;
    localparam ctrl_state_t ST_WAIT_RESULT = 3'd3;
    localparam ctrl_state_t ST_WRITE_BACK  = 3'd4;
    localparam ctrl_state_t ST_SETTLE      = 3'd5;
    localparam ctrl_state_t ST_COMMIT      = 3'd6;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_R) || (op == OP_I);
    endfunction

endpackage

// File: rtl/exec_op_controller.sv
// Multi-cycle controller for register/immediate ADD/SUB instructions.
// Sequences register-file read, operand issue to an external execution unit
// (STB/BUSY handshake), result capture, write-back, settle and commit.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start                    begin instruction (accepted in IDLE only)
//   op_type, op_sub          instruction type (R/I/illegal) and ADD/SUB mode
//   pc                       current PC; next_pc = latched pc + 1
//   src1_addr/src2_addr/dst_addr, imm   decoded instruction fields
//   rs1, rs2, rd             register-file addresses
//   rs1_val, rs2_val         register-file read data
//   wr_data, wr_en           register-file write port
//   unit_a/b/sub, unit_in_stb, unit_in_busy        operand channel
//   unit_result, unit_out_stb, unit_out_busy       result channel
//   busy, done, fetch_en, error                    status
module exec_op_controller
    import exec_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned PC_W       = 5,
    parameter int unsigned RF_RD_LAT  = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op_type,
    input  logic                  op_sub,
    input  logic [PC_W-1:0]       pc,
    input  logic [REG_ADDR_W-1:0] src1_addr,
    input  logic [REG_ADDR_W-1:0] src2_addr,
    input  logic [REG_ADDR_W-1:0] dst_addr,
    input  logic [DATA_W-1:0]     imm,
    output logic [REG_ADDR_W-1:0] rs1,
    output logic [REG_ADDR_W-1:0] rs2,
    output logic [REG_ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0]     rs1_val,
    input  logic [DATA_W-1:0]     rs2_val,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  wr_en,
    output logic [DATA_W-1:0]     unit_a,
    output logic [DATA_W-1:0]     unit_b,
    output logic                  unit_sub,
    output logic                  unit_in_stb,
    input  logic                  unit_in_busy,
    input  logic [DATA_W-1:0]     unit_result,
    input  logic                  unit_out_stb,
    output logic                  unit_out_busy,
    output logic [PC_W-1:0]       next_pc,
    output logic                  busy,
    output logic                  done,
    output logic                  fetch_en,
    output logic                  error
);

    // One counter serves both the RF read wait and the result timeout.
    localparam int unsigned CNT_MAX = (RF_RD_LAT > TIMEOUT) ? RF_RD_LAT : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    ctrl_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic                  is_r_q;
    logic [DATA_W-1:0]     imm_q;
    logic [DATA_W-1:0]     unit_a_q, unit_b_q;
    logic                  unit_sub_q;
    logic [DATA_W-1:0]     result_q;
    logic [PC_W-1:0]       next_pc_q;
    logic                  error_q;

    logic accept_start;
    logic rf_last;
    logic wait_expired;

    assign accept_start = (state_q == ST_IDLE) && start;
    assign rf_last      = (cnt_q == CNT_W'(RF_RD_LAT - 1));
    assign wait_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = op_is_legal(op_type) ? ST_RF_READ : ST_COMMIT;
                    cnt_d   = '0;
                end
            end
            ST_RF_READ: begin
                if (rf_last) begin
                    state_d = ST_ISSUE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!unit_in_busy) begin
                    state_d = ST_WAIT_RESULT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RESULT: begin
                // A result arriving in the last allowed cycle still wins.
                if (unit_out_stb) begin
                    state_d = ST_WRITE_BACK;
                end else if (wait_expired) begin
                    state_d = ST_COMMIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE_BACK: state_d = ST_SETTLE;
            ST_SETTLE:     state_d = ST_COMMIT;
            ST_COMMIT:     state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            is_r_q     <= 1'b0;
            imm_q      <= '0;
            unit_a_q   <= '0;
            unit_b_q   <= '0;
            unit_sub_q <= 1'b0;
            result_q   <= '0;
            next_pc_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept_start) begin
                rs1_q      <= src1_addr;
                rs2_q      <= src2_addr;
                rd_q       <= dst_addr;
                is_r_q     <= (op_type == OP_R);
                imm_q      <= imm;
                unit_sub_q <= op_sub;
                next_pc_q  <= pc + PC_W'(1);
                error_q    <= !op_is_legal(op_type);
            end
            if ((state_q == ST_RF_READ) && rf_last) begin
                unit_a_q <= rs1_val;
                unit_b_q <= is_r_q ? rs2_val : imm_q;
            end
            if (state_q == ST_WAIT_RESULT) begin
                if (unit_out_stb) begin
                    result_q <= unit_result;
                end else if (wait_expired) begin
                    error_q <= 1'b1;
                end
            end
        end
    end

    // Moore outputs: nothing here depends combinationally on start.
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign rd            = rd_q;
    assign wr_data       = result_q;
    assign wr_en         = (state_q == ST_WRITE_BACK) && (rd_q != '0);
    assign unit_a        = unit_a_q;
    assign unit_b        = unit_b_q;
    assign unit_sub      = unit_sub_q;
    assign unit_in_stb   = (state_q == ST_ISSUE);
    assign unit_out_busy = (state_q != ST_WAIT_RESULT);
    assign next_pc       = next_pc_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = (state_q == ST_COMMIT);
    assign fetch_en      = (state_q == ST_COMMIT);
    assign error         = error_q;

endmodule
